instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Fetch-side initiator for the 256 x 16-bit combinational instruction ROM.
//   - Owns the fetch PC and drives the ROM address.
//   - Captures the returned instruction word into a small prefetch FIFO.
//   - Presents instructions to decode over a valid/ready handshake.
//   - Handles branch redirects, fetch enable and a HALT opcode.
// PARAMETERS
//   ADDR_W      8      fetch PC / ROM address width
//   INSTR_W     16     instruction word width
//   RESET_PC    8'h00  fetch PC loaded on reset
//   FIFO_DEPTH  2      prefetch entries (>=2); each entry holds {pc, instr}
// PORTS
//   clk             in   1        rising-edge clock
//   rst_n           in   1        asynchronous, active-low reset
//   imem_addr       out  ADDR_W   ROM address; equals fetch PC register fpc
//   imem_instr      in   INSTR_W  ROM data; combinational, same cycle as imem_addr
//   fetch_en        in   1        1 = fetching permitted
//   redirect_valid  in   1        branch/jump taken; flush and restart
//   redirect_pc     in   ADDR_W   new fetch PC when redirect_valid
//   out_valid       out  1        FIFO head valid to decode
//   out_instr       out  INSTR_W  FIFO head instruction
//   out_pc          out  ADDR_W   FIFO head PC
//   out_ready       in   1        decode accepts head this cycle
//   halted          out  1        HALT fetched and FIFO drained
// BEHAVIOUR
//   Reset (async, rst_n=0), all values:
//     - fpc=RESET_PC, FIFO count=0, state=IDLE
//     - out_valid=0, out_instr=0, out_pc=0, halted=0
//   States:
//     - IDLE: no push. Goes to RUN when fetch_en=1.
//     - RUN: push when space. Goes to IDLE when fetch_en=0.
//       Goes to HALT when the pushed instr[15:12]==4'hF.
//     - HALT: no push. Exits only via redirect (to RUN if fetch_en=1, else IDLE)
//       or via reset.
//   Push (RUN, no redirect, and count<FIFO_DEPTH or a pop occurs this cycle):
//     - Write {fpc, imem_instr} to the FIFO tail.
//     - fpc <= fpc+1, modulo 2^ADDR_W (8'hFF wraps to 8'h00).
//   Pop: when out_valid && out_ready, the head advances.
//   Push and pop in the same cycle are legal: at full, count stays at
//     FIFO_DEPTH; at empty, the pushed entry becomes head next cycle.
//   Latency: instruction at fpc is visible on out_* the cycle after it is pushed.
//     - Empty FIFO with out_ready held high gives one instruction per cycle.
//   Handshake: while out_valid=1 && out_ready=0, out_valid, out_instr and out_pc
//     hold stable. out_valid never drops without a pop, redirect or reset.
//   Redirect has priority over push, pop and fetch_en:
//     - count <= 0, fpc <= redirect_pc; no push or pop that cycle.
//     - out_valid=0 the next cycle; first redirected instruction appears one
//       cycle after that.
//     - Same-cycle out_ready is ignored (head discarded, not consumed).
//   fetch_en=0 mid-stream: pushes stop next edge; FIFO contents and fpc are kept;
//     decode may keep draining.
//   halted = (state==HALT) && (count==0). The HALT word itself is delivered to
//     decode normally.
//   Reset asserted mid-operation: immediate return to reset values; in-flight
//     FIFO contents are lost.
// CONFIGURATION
//   FETCH_PERF_CNT_EN defined:
//     - Adds port perf_fetched (out, 16): count of pushes since reset.
//     - Saturates at 16'hFFFF; cleared by rst_n; not cleared by redirect.
//   FETCH_PERF_CNT_EN undefined: port and counter absent; behaviour otherwise identical.
// TESTING
//   ROM 0..3 = 1001,1002,1003,1004; fetch_en=1, out_ready=1 -> out_pc 0,1,2,3 on
//     consecutive cycles, first out_valid 2 cycles after reset release.
//   out_ready=0 for 5 cycles -> count=2, fpc=2, out_instr holds 16'h1001; ready=1
//     -> 1001,1002,1003 back-to-back.
//   Redirect to 8'h40 while FIFO full -> next cycle out_valid=0; then out_pc=8'h40;
//     old entries never delivered.
//   RESET_PC=8'hFE, ready=1 -> out_pc FE,FF,00,01 (wrap).
//   ROM[3]=16'hF000 -> out_pc 0..3 delivered, fetch stops, halted=1 after pop of
//     pc 3; redirect to 0 -> halted=0, refetch from 0.
//   FETCH_PERF_CNT_EN defined: 10 pushes, 2 redirects -> perf_fetched=10;
//     rst_n pulse -> 0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch-side initiator: owns the fetch PC, captures ROM words into a prefetch FIFO
// and hands {pc, instr} to decode over valid/ready. Optional FETCH_PERF_CNT_EN adds a push counter.
module instr_fetch_unit #(
    parameter int                ADDR_W     = 8,
    parameter int                INSTR_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               fetch_en,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    input  logic               out_ready,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0]        perf_fetched,
`endif
    output logic               halted
);

    // state | meaning
    // IDLE  | fetch disabled, no pushes
    // RUN   | pushing one word per cycle while the FIFO has (or is making) room
    // HALT  | HALT opcode captured; waits for a redirect
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  fpc_q, fpc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    entry_t             mem_q [FIFO_DEPTH];
    entry_t             mem_d [FIFO_DEPTH];
    logic               push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign imem_addr = fpc_q;
    assign out_valid = (cnt_q != '0);
    assign out_instr = out_valid ? mem_q[head_q].instr : '0;
    assign out_pc    = out_valid ? mem_q[head_q].pc    : '0;
    assign halted    = (state_q == HALT) && (cnt_q == '0);

    always_comb begin
        pop  = out_valid && out_ready && !redirect_valid;
        push = (state_q == RUN) && !redirect_valid &&
               ((cnt_q < CNT_W'(FIFO_DEPTH)) || pop);

        state_d = state_q;
        fpc_d   = fpc_q;
        cnt_d   = cnt_q;
        head_d  = head_q;
        tail_d  = tail_q;
        mem_d   = mem_q;

        if (redirect_valid) begin
            // Flush discards the head even if decode is accepting it this cycle.
            state_d = fetch_en ? RUN : IDLE;
            fpc_d   = redirect_pc;
            cnt_d   = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: if (fetch_en) state_d = RUN;
                RUN: begin
                    if (push && (imem_instr[INSTR_W-1 -: 4] == 4'hF)) state_d = HALT;
                    else if (!fetch_en)                               state_d = IDLE;
                end
                HALT:    state_d = HALT;
                default: state_d = IDLE;
            endcase

            if (push) begin
                mem_d[tail_q] = '{pc: fpc_q, instr: imem_instr};
                tail_d        = ptr_inc(tail_q);
                fpc_d         = fpc_q + ADDR_W'(1);
            end
            if (pop) head_d = ptr_inc(head_q);
            if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
            else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            fpc_q   <= RESET_PC;
            cnt_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            mem_q   <= mem_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_q, perf_d;

    // Survives redirects; only reset clears it.
    always_comb begin
        perf_d = perf_q;
        if (push && (perf_q != 16'hFFFF)) perf_d = perf_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perf_q <= '0;
        else        perf_q <= perf_d;
    end

    assign perf_fetched = perf_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a per-cycle vector table plus hand-written
// sequences for backpressure, redirect-while-full, HALT and the optional perf counter.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en, redirect_valid, out_ready;
    logic [7:0]  redirect_pc;
    logic [15:0] rom [256];

    logic [7:0]  addr0, addr1, p0, p1;
    logic [15:0] instr0, instr1, i0, i1;
    logic        v0, v1, h0, h1;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf0, perf1;
`endif

    always #5 clk = ~clk;

    assign instr0 = rom[addr0];
    assign instr1 = rom[addr1];

    instr_fetch_unit dut0 (
        .clk(clk), .rst_n(rst_n), .imem_addr(addr0), .imem_instr(instr0),
        .fetch_en(fetch_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(v0), .out_instr(i0), .out_pc(p0), .out_ready(out_ready),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched(perf0),
`endif
        .halted(h0)
    );

    instr_fetch_unit #(.RESET_PC(8'hFE)) dut1 (
        .clk(clk), .rst_n(rst_n), .imem_addr(addr1), .imem_instr(instr1),
        .fetch_en(fetch_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(v1), .out_instr(i1), .out_pc(p1), .out_ready(out_ready),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched(perf1),
`endif
        .halted(h1)
    );

    typedef struct {
        logic       fe;
        logic       rv;
        logic [7:0] rpc;
        logic       rdy;
        logic       ev;
        logic [7:0] epc;
        logic [15:0] ei;
        logic       chk1;
        logic [7:0] epc1;
    } vec_t;

    vec_t vt [19];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic fe, input logic rv, input logic [7:0] rpc,
                                input logic rdy, input logic ev, input logic [7:0] epc,
                                input logic [15:0] ei, input logic chk1, input logic [7:0] epc1);
        vec_t v;
        v.fe = fe; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.ev = ev;
        v.epc = epc; v.ei = ei; v.chk1 = chk1; v.epc1 = epc1;
        return v;
    endfunction

    initial begin
        for (int a = 0; a < 256; a++) rom[a] = 16'h1000 + 16'(a) + 16'd1;

        //           fe   rv   rpc    rdy  ev   epc    ei        chk1 epc1
        vt[0]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00);
        vt[1]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 16'h1001, 1'b1, 8'hFE);
        vt[2]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 16'h1002, 1'b1, 8'hFF);
        vt[3]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 16'h1003, 1'b1, 8'h00);
        vt[4]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 16'h1004, 1'b1, 8'h01);
        vt[5]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 16'h1004, 1'b0, 8'h00);
        vt[6]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 16'h1004, 1'b0, 8'h00);
        vt[7]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 16'h1005, 1'b0, 8'h00);
        vt[8]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h05, 16'h1006, 1'b0, 8'h00);
        vt[9]  = mk(1'b1, 1'b1, 8'h40, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00);
        vt[10] = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h40, 16'h1041, 1'b0, 8'h00);
        vt[11] = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 16'h1042, 1'b0, 8'h00);
        vt[12] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h41, 16'h1042, 1'b0, 8'h00);
        vt[13] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h41, 16'h1042, 1'b0, 8'h00);
        vt[14] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h42, 16'h1043, 1'b0, 8'h00);
        vt[15] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00);
        vt[16] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00);
        vt[17] = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00);
        vt[18] = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h43, 16'h1044, 1'b0, 8'h00);

        rst_n = 1'b1;
        fetch_en = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 8'h00;
        out_ready = 1'b1;

        // Reset values, sampled while reset is held
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(v0), 32'h0);
        chk("rst_instr", 32'(i0), 32'h0);
        chk("rst_pc", 32'(p0), 32'h0);
        chk("rst_halted", 32'(h0), 32'h0);
        chk("rst_addr", 32'(addr0), 32'h00);
        chk("rst_addr_fe", 32'(addr1), 32'hFE);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Streaming, backpressure, redirect, fetch_en drop/resume; dut1 shows PC wrap
        for (int k = 0; k < 19; k++) begin
            fetch_en       = vt[k].fe;
            redirect_valid = vt[k].rv;
            redirect_pc    = vt[k].rpc;
            out_ready      = vt[k].rdy;
            cyc();
            chk($sformatf("vec%0d_valid", k), 32'(v0), 32'(vt[k].ev));
            chk($sformatf("vec%0d_halted", k), 32'(h0), 32'h0);
            if (vt[k].ev) begin
                chk($sformatf("vec%0d_pc", k), 32'(p0), 32'(vt[k].epc));
                chk($sformatf("vec%0d_instr", k), 32'(i0), 32'(vt[k].ei));
            end
            if (vt[k].chk1) begin
                chk($sformatf("vec%0d_wrap_valid", k), 32'(v1), 32'h1);
                chk($sformatf("vec%0d_wrap_pc", k), 32'(p1), 32'(vt[k].epc1));
            end
        end
        redirect_valid = 1'b0;

        // Backpressure from reset: FIFO fills, fpc parks at 2
        fetch_en = 1'b1;
        out_ready = 1'b0;
        do_reset();
        repeat (5) cyc();
        chk("bp_fpc", 32'(addr0), 32'h02);
        chk("bp_valid", 32'(v0), 32'h1);
        chk("bp_hold_instr", 32'(i0), 32'h1001);
        chk("bp_hold_pc", 32'(p0), 32'h00);
        out_ready = 1'b1;
        #1;
        chk("bp_first", 32'(i0), 32'h1001);
        cyc();
        chk("bp_second", 32'(i0), 32'h1002);
        cyc();
        chk("bp_third", 32'(i0), 32'h1003);

        // Redirect while full: old entries dropped, same-cycle ready ignored
        out_ready = 1'b0;
        cyc();
        chk("full_before_redir", 32'(p0), 32'h02);
        redirect_valid = 1'b1;
        redirect_pc = 8'h40;
        out_ready = 1'b1;
        cyc();
        chk("redir_bubble", 32'(v0), 32'h0);
        redirect_valid = 1'b0;
        cyc();
        chk("redir_valid", 32'(v0), 32'h1);
        chk("redir_pc0", 32'(p0), 32'h40);
        cyc();
        chk("redir_pc1", 32'(p0), 32'h41);
        cyc();
        chk("redir_pc2", 32'(p0), 32'h42);

        // HALT at pc 3
        rom[3] = 16'hF000;
        fetch_en = 1'b1;
        out_ready = 1'b1;
        do_reset();
        repeat (4) cyc();
        chk("halt_pre_pc", 32'(p0), 32'h02);
        cyc();
        chk("halt_word_pc", 32'(p0), 32'h03);
        chk("halt_word", 32'(i0), 32'hF000);
        chk("halt_not_yet", 32'(h0), 32'h0);
        cyc();
        chk("halt_drained_valid", 32'(v0), 32'h0);
        chk("halted_set", 32'(h0), 32'h1);
        cyc();
        chk("halt_sticky", 32'(h0), 32'h1);
        chk("halt_fpc", 32'(addr0), 32'h04);
        redirect_valid = 1'b1;
        redirect_pc = 8'h00;
        cyc();
        chk("halt_exit", 32'(h0), 32'h0);
        chk("halt_exit_valid", 32'(v0), 32'h0);
        redirect_valid = 1'b0;
        cyc();
        chk("refetch_valid", 32'(v0), 32'h1);
        chk("refetch_pc", 32'(p0), 32'h00);
        chk("refetch_instr", 32'(i0), 32'h1001);
        rom[3] = 16'h1004;

`ifdef FETCH_PERF_CNT_EN
        // 10 pushes across two redirects
        fetch_en = 1'b1;
        out_ready = 1'b1;
        redirect_pc = 8'h40;
        do_reset();
        cyc();
        repeat (5) cyc();
        redirect_valid = 1'b1;
        cyc();
        redirect_valid = 1'b0;
        repeat (5) cyc();
        redirect_valid = 1'b1;
        fetch_en = 1'b0;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        chk("perf_count", 32'(perf0), 32'd10);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("perf_reset", 32'(perf0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
